// File: rtl/gate_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_pkg
// Desc     : Shared types, default polynomials and the Galois step helper for
//            the gate-model BIST harness.
// Revision : 1.0 - initial release
// ============================================================================
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         c_MAX_W          = 64;
    localparam logic [9:0] c_DEF_LFSR_POLY  = 10'h240;
    localparam logic [9:0] c_DEF_LFSR_SEED  = 10'h001;
    localparam logic [9:0] c_DEF_MISR_POLY  = 10'h240;

    // Right-shifting Galois step; bits above width are cleared.
    function automatic logic [c_MAX_W-1:0] galois_step(
        input logic [c_MAX_W-1:0] value,
        input logic [c_MAX_W-1:0] mask,
        input int                 width
    );
        logic [c_MAX_W-1:0] v;
        logic [c_MAX_W-1:0] keep;
        v = value >> 1;
        if (value[0]) begin
            v = v ^ mask;
        end
        keep = (width >= c_MAX_W) ? {c_MAX_W{1'b1}}
                                  : ((c_MAX_W'(1) << width) - c_MAX_W'(1));
        return v & keep;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_bist_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_lfsr
// Desc     : Galois shift register usable as pattern generator (din tied 0)
//            or as a MISR compacting din.
// Revision : 1.0 - initial release
// ============================================================================
module gate_bist_lfsr
    import gate_bist_pkg::*;
#(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] POLY      = c_DEF_LFSR_POLY,
    parameter logic [WIDTH-1:0] SEED      = c_DEF_LFSR_SEED,
    parameter bit               MISR_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    // A generator must never start from the all-zero lock-up state.
    localparam logic [WIDTH-1:0] c_INIT =
        MISR_MODE ? {WIDTH{1'b0}}
                  : ((SEED == {WIDTH{1'b0}}) ? WIDTH'(1) : SEED);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    assign w_next = WIDTH'(galois_step(c_MAX_W'(r_q), c_MAX_W'(POLY), WIDTH)) ^ din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= c_INIT;
        end else if (load) begin
            r_q <= c_INIT;
        end else if (step) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/gate_model_bist.sv
`default_nettype none
// ============================================================================
// Module   : gate_model_bist
// Desc     : LFSR/MISR self-test wrapper for combinational or pipelined gate
//            models, with golden-signature comparison.
// Revision : 1.0 - initial release
// ============================================================================
module gate_model_bist
    import gate_bist_pkg::*;
#(
    parameter int              N_IN      = 10,
    parameter int              N_OUT     = 10,
    parameter int              PATTERNS  = 1023,
    parameter int              CNT_W     = 16,
    parameter int              DUT_LAT   = 0,
    parameter logic [N_IN-1:0] LFSR_POLY = c_DEF_LFSR_POLY,
    parameter logic [N_IN-1:0] LFSR_SEED = c_DEF_LFSR_SEED,
    parameter logic [N_OUT-1:0] MISR_POLY = c_DEF_MISR_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] expected_sig,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_OUT-1:0] signature
);

    generate
        if (N_IN < 2 || N_IN > c_MAX_W || N_OUT < 2 || N_OUT > c_MAX_W ||
            DUT_LAT < 0 || DUT_LAT > 7 || PATTERNS < 1 ||
            64'(PATTERNS) >= (64'd1 << CNT_W)) begin : g_bad_params
            $error("gate_model_bist: illegal parameter combination");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_LAST       = CNT_W'(PATTERNS - 1);
    localparam logic [2:0]       c_DRAIN_LAST = 3'(DUT_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_drain;
    logic             w_start_ok;
    logic             w_run_step;
    logic             w_capture;

    // abort outranks start, including a simultaneous request in IDLE.
    assign w_start_ok = start & ~abort & ((r_state == IDLE) | (r_state == DONE));
    assign w_run_step = (r_state == RUN) & ~abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (abort)                w_state_nxt = IDLE;
                else if (r_cnt == c_LAST) w_state_nxt = (DUT_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort)                         w_state_nxt = IDLE;
                else if (r_drain == c_DRAIN_LAST)  w_state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (abort)           w_state_nxt = IDLE;
                else if (w_start_ok) w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_drain <= '0;
        end else if (w_start_ok) begin
            r_cnt   <= '0;
            r_drain <= '0;
        end else if (w_run_step) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_drain <= '0;
        end else if ((r_state == DRAIN) && !abort) begin
            r_drain <= r_drain + 3'd1;
        end
    end

    // Valid bit delayed by the model latency decides when a response is real.
    generate
        if (DUT_LAT == 0) begin : g_lat0
            assign w_capture = w_run_step;
        end else begin : g_latn
            logic [DUT_LAT-1:0] r_vpipe;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vpipe <= '0;
                end else if (w_start_ok || abort) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= DUT_LAT'({r_vpipe, (r_state == RUN)});
                end
            end
            assign w_capture = r_vpipe[DUT_LAT-1] & ~abort;
        end
    endgenerate

    gate_bist_lfsr #(
        .WIDTH     (N_IN),
        .POLY      (LFSR_POLY),
        .SEED      (LFSR_SEED),
        .MISR_MODE (1'b0)
    ) u_gen (
        .clk  (clk),
        .rst  (rst),
        .load (w_start_ok),
        .step (w_run_step),
        .din  ({N_IN{1'b0}}),
        .q    (dut_in)
    );

    gate_bist_lfsr #(
        .WIDTH     (N_OUT),
        .POLY      (MISR_POLY),
        .SEED      ({N_OUT{1'b0}}),
        .MISR_MODE (1'b1)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (w_start_ok),
        .step (w_capture),
        .din  (dut_out),
        .q    (signature)
    );

    assign pass = done & (signature == expected_sig);

endmodule
`default_nettype wire
